// File: rtl/dmem_responder.sv
// dmem_responder: single-outstanding data-memory responder with a fixed,
// parameterised response latency. A request is accepted in IDLE, waits
// WAIT_STATES cycles in WAIT, and its response is held in RESP until the
// initiator takes it. Misaligned or out-of-range requests come back with
// resp_err set, no data, and no effect on storage.
//
// Optional feature: define DMEM_BYTE_STROBE_EN to add the req_be[3:0] byte
// lane enables for stores. Without it every valid store writes all four lanes.
//
// Storage is never cleared by reset; only the control path and the response
// registers are.

module dmem_responder #(
  parameter int DEPTH_WORDS = 256,
  parameter int WAIT_STATES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
`ifdef DMEM_BYTE_STROBE_EN
  input  logic [3:0]  req_be,
`endif
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err
);

  // Word index width into the storage array.
  localparam int AW = $clog2(DEPTH_WORDS);

  // Value loaded into the wait counter on accept. With zero wait states the
  // counter is not used, so it is simply parked at zero.
  localparam logic [3:0] CNT_LOAD = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t      state;
  logic [3:0]  cnt;

  // Request fields captured on accept; the request inputs are ignored after
  // that until the response handshake completes.
  logic        cap_write;
  logic [31:0] cap_addr;
  logic [31:0] cap_wdata;
`ifdef DMEM_BYTE_STROBE_EN
  logic [3:0]  cap_be;
`endif

  // Storage; deliberately has no reset.
  logic [31:0] mem [DEPTH_WORDS];

  // Effective request: the live inputs while in IDLE (only matters for the
  // zero-wait-state path, where accept and commit share one edge), otherwise
  // the captured copy.
  logic          accept;
  logic          eff_write;
  logic [31:0]   eff_addr;
  logic [31:0]   eff_wdata;
  logic [3:0]    eff_be;
  logic          eff_err;
  logic [AW-1:0] eff_idx;
  logic          enter_resp;
  logic          commit_store;
  logic [31:0]   load_data;

  assign accept = req_valid && req_ready;

  // Select between live request inputs and captured fields, and decode errors.
  always_comb begin
    eff_write = cap_write;
    eff_addr  = cap_addr;
    eff_wdata = cap_wdata;
`ifdef DMEM_BYTE_STROBE_EN
    eff_be    = cap_be;
`else
    eff_be    = 4'hF;
`endif
    if (state == IDLE) begin
      eff_write = req_write;
      eff_addr  = req_addr;
      eff_wdata = req_wdata;
`ifdef DMEM_BYTE_STROBE_EN
      eff_be    = req_be;
`else
      eff_be    = 4'hF;
`endif
    end
    eff_err = (eff_addr[1:0] != 2'b00) || (eff_addr[31:2] >= 30'(DEPTH_WORDS));
    eff_idx = eff_addr[AW+1:2];
  end

  // Decide whether this edge moves into RESP, which is the single point where
  // stores commit and load data is sampled.
  always_comb begin
    enter_resp = 1'b0;
    if (state == WAIT && cnt == 4'd0) begin
      enter_resp = 1'b1;
    end else if (state == IDLE && accept && WAIT_STATES == 0) begin
      enter_resp = 1'b1;
    end
    commit_store = enter_resp && eff_write && !eff_err;
    load_data    = 32'd0;
    if (!eff_write && !eff_err) begin
      load_data = mem[eff_idx];
    end
  end

  // Storage write port: a valid store commits its enabled lanes on the edge
  // into RESP; an asserted reset on that same edge aborts the commit.
  always_ff @(posedge clk) begin
    if (reset && commit_store) begin
      for (int i = 0; i < 4; i++) begin
        if (eff_be[i]) begin
          mem[eff_idx][8*i +: 8] <= eff_wdata[8*i +: 8];
        end
      end
    end
  end

  // Control FSM with registered handshake and response outputs.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state      <= IDLE;
      cnt        <= 4'd0;
      req_ready  <= 1'b1;
      resp_valid <= 1'b0;
      resp_rdata <= 32'd0;
      resp_err   <= 1'b0;
      cap_write  <= 1'b0;
      cap_addr   <= 32'd0;
      cap_wdata  <= 32'd0;
`ifdef DMEM_BYTE_STROBE_EN
      cap_be     <= 4'd0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            cap_write <= req_write;
            cap_addr  <= req_addr;
            cap_wdata <= req_wdata;
`ifdef DMEM_BYTE_STROBE_EN
            cap_be    <= req_be;
`endif
            req_ready <= 1'b0;
            if (enter_resp) begin
              state      <= RESP;
              cnt        <= 4'd0;
              resp_valid <= 1'b1;
              resp_rdata <= load_data;
              resp_err   <= eff_err;
            end else begin
              state <= WAIT;
              cnt   <= CNT_LOAD;
            end
          end
        end

        WAIT: begin
          if (enter_resp) begin
            state      <= RESP;
            resp_valid <= 1'b1;
            resp_rdata <= load_data;
            resp_err   <= eff_err;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end

        RESP: begin
          if (resp_ready) begin
            state      <= IDLE;
            req_ready  <= 1'b1;
            resp_valid <= 1'b0;
            resp_rdata <= 32'd0;
            resp_err   <= 1'b0;
          end
        end

        default: begin
          state      <= IDLE;
          cnt        <= 4'd0;
          req_ready  <= 1'b1;
          resp_valid <= 1'b0;
          resp_rdata <= 32'd0;
          resp_err   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder: directed test of dmem_responder at WAIT_STATES = 2 and
// DEPTH_WORDS = 256. Byte-strobe steps run only when DMEM_BYTE_STROBE_EN is
// defined for both the design and this bench.

module tb_dmem_responder;

  localparam int DEPTH_WORDS = 256;
  localparam int WAIT_STATES = 2;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [3:0]  req_be;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_rdata;
  logic        resp_err;

  int checks   = 0;
  int failures = 0;

  dmem_responder #(
    .DEPTH_WORDS(DEPTH_WORDS),
    .WAIT_STATES(WAIT_STATES)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_write (req_write),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
`ifdef DMEM_BYTE_STROBE_EN
    .req_be    (req_be),
`endif
    .resp_valid(resp_valid),
    .resp_ready(resp_ready),
    .resp_rdata(resp_rdata),
    .resp_err  (resp_err)
  );

  // 10 ns clock.
  always #5 clk = ~clk;

  // Safety net so the run can never hang.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  // One comparison: counts it and reports a failure with tag and values.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      failures++;
      $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, observed, expected);
    end
  endtask

  // Full transaction: present a request, keep junk on the request port while
  // it is in flight, measure latency, hold the response for 'hold' cycles of
  // backpressure, then complete the handshake. Called #1 after a rising edge.
  task automatic applyStimulus(input string name, input logic w,
                               input logic [31:0] a, input logic [31:0] d,
                               input logic [3:0] be, input logic [31:0] exp_rdata,
                               input logic exp_err, input int hold);
    logic accepted;
    int   lat;
    req_valid = 1'b1;
    req_write = w;
    req_addr  = a;
    req_wdata = d;
    req_be    = be;
    accepted  = 1'b0;
    for (int n = 0; n < 20 && !accepted; n++) begin
      if (req_ready === 1'b1) accepted = 1'b1;
      @(posedge clk);
      #1;
    end
    checkOutput({name, ":accept"}, 32'(accepted), 32'd1);

    // Junk store to word 0 while busy; it must be ignored.
    req_valid = 1'b1;
    req_write = 1'b1;
    req_addr  = 32'h0000_0000;
    req_wdata = 32'hBAD0_BAD0;
    req_be    = 4'hF;

    // lat = edges after the accept edge up to the first edge that samples
    // resp_valid high; expected 1 + WAIT_STATES.
    lat = 1;
    while (resp_valid !== 1'b1 && lat < 40) begin
      @(posedge clk);
      #1;
      lat++;
    end
    req_valid = 1'b0;
    checkOutput({name, ":latency"}, 32'(lat), 32'(1 + WAIT_STATES));
    checkOutput({name, ":rdata"}, resp_rdata, exp_rdata);
    checkOutput({name, ":err"}, 32'(resp_err), 32'(exp_err));

    for (int k = 0; k < hold; k++) begin
      @(posedge clk);
      #1;
      checkOutput({name, ":hold_valid"}, 32'(resp_valid), 32'd1);
      checkOutput({name, ":hold_rdata"}, resp_rdata, exp_rdata);
      checkOutput({name, ":hold_err"}, 32'(resp_err), 32'(exp_err));
      checkOutput({name, ":hold_ready"}, 32'(req_ready), 32'd0);
    end

    resp_ready = 1'b1;
    @(posedge clk);
    #1;
    resp_ready = 1'b0;
    checkOutput({name, ":post_valid"}, 32'(resp_valid), 32'd0);
    checkOutput({name, ":post_ready"}, 32'(req_ready), 32'd1);
  endtask

  // Directed sequence.
  initial begin
    reset      = 1'b0;
    req_valid  = 1'b0;
    req_write  = 1'b0;
    req_addr   = 32'd0;
    req_wdata  = 32'd0;
    req_be     = 4'hF;
    resp_ready = 1'b0;

    repeat (3) @(posedge clk);
    #1;
    checkOutput("rst:req_ready", 32'(req_ready), 32'd1);
    checkOutput("rst:resp_valid", 32'(resp_valid), 32'd0);
    checkOutput("rst:resp_rdata", resp_rdata, 32'd0);
    checkOutput("rst:resp_err", 32'(resp_err), 32'd0);
    reset = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("rst_rel:req_ready", 32'(req_ready), 32'd1);

    // Store then load.
    applyStimulus("st_10", 1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 4'hF, 32'd0, 1'b0, 0);
    applyStimulus("ld_10", 1'b0, 32'h0000_0010, 32'd0, 4'hF, 32'hDEAD_BEEF, 1'b0, 0);

    // Misaligned load, storage untouched.
    applyStimulus("st_04", 1'b1, 32'h0000_0004, 32'h0404_0404, 4'hF, 32'd0, 1'b0, 0);
    applyStimulus("ld_06", 1'b0, 32'h0000_0006, 32'd0, 4'hF, 32'd0, 1'b1, 0);
    applyStimulus("ld_04", 1'b0, 32'h0000_0004, 32'd0, 4'hF, 32'h0404_0404, 1'b0, 0);

    // Misaligned store must not land on the aligned word.
    applyStimulus("st_12", 1'b1, 32'h0000_0012, 32'h5555_5555, 4'hF, 32'd0, 1'b1, 0);
    applyStimulus("ld_10b", 1'b0, 32'h0000_0010, 32'd0, 4'hF, 32'hDEAD_BEEF, 1'b0, 0);

    // Out-of-range store (word 256 would alias word 0 if truncated).
    applyStimulus("st_00", 1'b1, 32'h0000_0000, 32'h0000_A5A5, 4'hF, 32'd0, 1'b0, 0);
    applyStimulus("st_400", 1'b1, 32'h0000_0400, 32'hFFFF_FFFF, 4'hF, 32'd0, 1'b1, 0);
    applyStimulus("ld_00", 1'b0, 32'h0000_0000, 32'd0, 4'hF, 32'h0000_A5A5, 1'b0, 0);

    // Last valid word, and first out-of-range load.
    applyStimulus("st_3fc", 1'b1, 32'h0000_03FC, 32'h3FC0_FFEE, 4'hF, 32'd0, 1'b0, 0);
    applyStimulus("ld_3fc", 1'b0, 32'h0000_03FC, 32'd0, 4'hF, 32'h3FC0_FFEE, 1'b0, 0);
    applyStimulus("ld_400", 1'b0, 32'h0000_0400, 32'd0, 4'hF, 32'd0, 1'b1, 0);

    // Backpressure for 5 cycles.
    applyStimulus("bp_ld_10", 1'b0, 32'h0000_0010, 32'd0, 4'hF, 32'hDEAD_BEEF, 1'b0, 5);

    // Reset one edge after accept of a store: nothing committed.
    applyStimulus("st_20", 1'b1, 32'h0000_0020, 32'hCAFE_0020, 4'hF, 32'd0, 1'b0, 0);
    req_valid = 1'b1;
    req_write = 1'b1;
    req_addr  = 32'h0000_0020;
    req_wdata = 32'h1234_5678;
    req_be    = 4'hF;
    checkOutput("rstw:ready_before", 32'(req_ready), 32'd1);
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    reset     = 1'b0;
    checkOutput("rstw:in_wait", 32'(req_ready), 32'd0);
    @(posedge clk);
    #1;
    checkOutput("rstw:req_ready", 32'(req_ready), 32'd1);
    checkOutput("rstw:resp_valid", 32'(resp_valid), 32'd0);
    checkOutput("rstw:resp_rdata", resp_rdata, 32'd0);
    checkOutput("rstw:resp_err", 32'(resp_err), 32'd0);
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("rstw:no_stale_resp", 32'(resp_valid), 32'd0);
    applyStimulus("ld_20", 1'b0, 32'h0000_0020, 32'd0, 4'hF, 32'hCAFE_0020, 1'b0, 0);

`ifdef DMEM_BYTE_STROBE_EN
    // Byte lanes 0 and 2 only, then an all-lanes-off no-op store.
    applyStimulus("be_full", 1'b1, 32'h0000_0000, 32'h1122_3344, 4'hF, 32'd0, 1'b0, 0);
    applyStimulus("be_0101", 1'b1, 32'h0000_0000, 32'hAABB_CCDD, 4'b0101, 32'd0, 1'b0, 0);
    applyStimulus("be_none", 1'b1, 32'h0000_0000, 32'hFFFF_FFFF, 4'b0000, 32'd0, 1'b0, 0);
    applyStimulus("be_ld", 1'b0, 32'h0000_0000, 32'd0, 4'hF, 32'h11BB_33DD, 1'b0, 0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
